dmem_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory between two requesters: the processor datapath load/store port (cpu) and an external loader/debug port (ext).
- Sits between the datapath's memory access signals and the data memory instance.
- Runs a fixed multi-cycle access per transaction and returns a one-cycle ack to the winning requester.
- Raises a stall to the processor to freeze PC update while a cpu access is pending.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_prio.sv | 55 +++++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e  : arbiter FSM states (IDLE / BUSY)
//   req_id_e : requester identity (REQ_CPU / REQ_EXT)
//   ADDR_W, DATA_W : memory address and data widths
package dmem_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_EXT = 1'b1
    } req_id_e;
endpackage

// File: rtl/dmem_arb_prio.sv
// Winner selection and starvation counter for the data-memory arbiter.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   cpu_req_i/ext_req_i : raw requests
//   cpu_ack_i/ext_ack_i : acks currently being presented (requester not eligible)
//   grant_i           : the top accepted winner_o this cycle
//   winner_o          : requester selected by priority
//   grant_valid_o     : winner_o is requesting and eligible this cycle
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    cpu_req_i,
    input  logic    ext_req_i,
    input  logic    cpu_ack_i,
    input  logic    ext_ack_i,
    input  logic    grant_i,
    output req_id_e winner_o,
    output logic    grant_valid_o
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_q;

    // Priority is decided on the raw requests; the ack mask only blocks the
    // grant. So while cpu keeps requesting, its ack cycle is an idle slot
    // rather than a free win for ext, and ext only gets in via starvation.
    always_comb begin
        winner_o = REQ_CPU;
        if (ext_req_i && (!cpu_req_i || starve_q == LIMIT)) begin
            winner_o = REQ_EXT;
        end
        if (winner_o == REQ_EXT) begin
            grant_valid_o = ext_req_i && !ext_ack_i;
        end else begin
            grant_valid_o = cpu_req_i && !cpu_ack_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (grant_i) begin
            if (winner_o == REQ_EXT) begin
                starve_q <= '0;
            end else if (ext_req_i && starve_q != LIMIT) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port 16-bit data memory between the cpu load/store port
// and an external loader/debug port. Each transaction drives the memory for
// ACC_CYCLES cycles, then pulses a one-cycle ack to the winner.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      : cpu request (held until cpu_ack)
//   cpu_rdata, cpu_ack         : cpu read data (held) and completion pulse
//   cpu_stall                  : cpu_req & ~cpu_ack, freezes the PC
//   ext_req/we/addr/wdata      : ext request (held until ext_ack)
//   ext_rdata, ext_ack         : ext read data (held) and completion pulse
//   mem_addr/wdata/we/re       : memory interface, registered
//   mem_rdata                  : memory read data, sampled on last access cycle
//   dbg_state                  : current FSM state for observation
// Handshake: a requester raises req with its we/addr/wdata stable and keeps
// them until it sees its ack for one cycle; ack is never raised without a
// prior granted req, and the two acks are never high together.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ACC_CYCLES   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_e            dbg_state
);
    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    state_e            state_q;
    req_id_e           id_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              cpu_ack_q;
    logic              ext_ack_q;

    req_id_e           winner;
    logic              grant_valid;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign grant = (state_q == IDLE) && grant_valid;

    dmem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_i     (cpu_req),
        .ext_req_i     (ext_req),
        .cpu_ack_i     (cpu_ack_q),
        .ext_ack_i     (ext_ack_q),
        .grant_i       (grant),
        .winner_o      (winner),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == REQ_EXT) begin
            sel_we    = ext_we;
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
        end
    end

    // The memory outputs are registered, so mem_we is set one cycle ahead:
    // on entry when the access is a single cycle, else when cnt is about to
    // reach zero. That yields exactly one write pulse, on the last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= REQ_CPU;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q     <= BUSY;
                        id_q        <= winner;
                        we_q        <= sel_we;
                        cnt_q       <= CNT_W'(ACC_CYCLES - 1);
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_re_q    <= !sel_we;
                        mem_we_q    <= (ACC_CYCLES == 1) ? sel_we : 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q    <= cnt_q - 1'b1;
                        mem_we_q <= we_q && (cnt_q == CNT_W'(1));
                    end else begin
                        state_q     <= IDLE;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_we_q    <= 1'b0;
                        mem_re_q    <= 1'b0;
                        if (id_q == REQ_EXT) begin
                            ext_ack_q <= 1'b1;
                            if (!we_q) ext_rdata_q <= mem_rdata;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!we_q) cpu_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT (default build) ----------------
    logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
    logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ext_ack, mem_we, mem_re;
    state_e      dbg_state;
    logic [15:0] mem [0:255];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    // ---------------- DUT (ACC_CYCLES=1 build) ----------------
    logic        c1_req = 0;
    logic [15:0] c1_addr = 0;
    logic [15:0] c1_rdata, e1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        c1_ack, c1_stall, e1_ack, m1_we, m1_re;
    logic        z1 = 1'b0;
    logic [15:0] z16 = 16'h0;
    state_e      d1_state;

    dmem_arbiter #(.ACC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(c1_req), .cpu_we(z1), .cpu_addr(c1_addr), .cpu_wdata(z16),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack), .cpu_stall(c1_stall),
        .ext_req(z1), .ext_we(z1), .ext_addr(z16), .ext_wdata(z16),
        .ext_rdata(e1_rdata), .ext_ack(e1_ack),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_re(m1_re),
        .mem_rdata(m1_rdata), .dbg_state(d1_state)
    );
    assign m1_rdata = m1_addr ^ 16'h5555;

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
        checks++; if ({cpu_ack, ext_ack, cpu_stall, mem_we, mem_re} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {cpu_ack, ext_ack, cpu_stall, mem_we, mem_re}); end
        checks++; if ({cpu_rdata, ext_rdata, mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {cpu_rdata, ext_rdata, mem_addr, mem_wdata}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cpu_read();
        mem[8'h10] = 16'h1234;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;          // cycle 0
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c0 got %b exp 1", cpu_stall); end
        step();                                                 // cycle 1
        checks++; if ({dbg_state, mem_re, mem_we} !== {BUSY, 2'b10}) begin errors++; $display("FAIL rd_c1 got %b exp 110", {dbg_state, mem_re, mem_we}); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr got %h exp 0010", mem_addr); end
        step();                                                 // cycle 2
        checks++; if ({mem_re, cpu_stall, cpu_ack} !== 3'b110) begin errors++; $display("FAIL rd_c2 got %b exp 110", {mem_re, cpu_stall, cpu_ack}); end
        step();                                                 // cycle 3
        checks++; if ({cpu_ack, ext_ack, mem_re, cpu_stall} !== 4'b1000) begin errors++; $display("FAIL rd_c3 got %b exp 1000", {cpu_ack, ext_ack, mem_re, cpu_stall}); end
        checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data got %h exp 1234", cpu_rdata); end
        cpu_req = 0;
        step();                                                 // cycle 4
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL rd_hold got %h exp 01234", {cpu_ack, cpu_rdata}); end
    endtask

    task automatic test_ext_write();
        mem[8'h30] = 16'h5A5A;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0030;
        repeat (3) step();
        checks++; if ({ext_ack, cpu_ack, ext_rdata, cpu_rdata} !== {2'b10, 16'h5A5A, 16'h1234}) begin errors++; $display("FAIL ext_rd got %h exp 2_5a5a_1234", {ext_ack, cpu_ack, ext_rdata, cpu_rdata}); end
        ext_req = 0;
        step();
        ext_req = 1; ext_we = 1; ext_addr = 16'h0004; ext_wdata = 16'hBEEF;
        step();                                                 // cycle 1
        checks++; if ({mem_we, mem_re, mem_addr} !== {2'b00, 16'h0004}) begin errors++; $display("FAIL wr_c1 got %h exp 0_0004", {mem_we, mem_re, mem_addr}); end
        step();                                                 // cycle 2
        checks++; if ({mem_we, mem_wdata, mem_addr} !== {1'b1, 16'hBEEF, 16'h0004}) begin errors++; $display("FAIL wr_c2 got %h exp 1_beef_0004", {mem_we, mem_wdata, mem_addr}); end
        step();                                                 // cycle 3
        checks++; if ({ext_ack, mem_we, ext_rdata} !== {2'b10, 16'h5A5A}) begin errors++; $display("FAIL wr_c3 got %h exp 2_5a5a", {ext_ack, mem_we, ext_rdata}); end
        ext_req = 0; ext_we = 0;
        step();
        checks++; if (mem[8'h04] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem got %h exp beef", mem[8'h04]); end
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h00AA;
        repeat (3) step();                                      // cycle 3
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", cpu_ack); end
        cpu_we = 0;
        step();                                                 // cycle 4: idle slot
        checks++; if ({dbg_state, mem_re} !== {IDLE, 1'b0}) begin errors++; $display("FAIL b2b_idle got %b exp 00", {dbg_state, mem_re}); end
        step();                                                 // cycle 5
        checks++; if ({dbg_state, mem_re, mem_addr} !== {BUSY, 1'b1, 16'h0020}) begin errors++; $display("FAIL b2b_busy got %h exp 3_0020", {dbg_state, mem_re, mem_addr}); end
        repeat (2) step();                                      // cycle 7
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h00AA}) begin errors++; $display("FAIL b2b_rd got %h exp 1_00aa", {cpu_ack, cpu_rdata}); end
        cpu_req = 0;
        step();
    endtask

    task automatic test_starvation();
        logic exp_order [0:9];
        logic got_order [0:9];
        int   n = 0;
        for (int i = 0; i < 10; i++) exp_order[i] = (i % 5 == 4);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0030;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            step();
            if (cpu_ack && ext_ack) begin
                checks++; errors++;
                $display("FAIL starve_overlap got 11 exp not both");
            end
            if (cpu_ack || ext_ack) begin
                got_order[n] = ext_ack;
                n++;
            end
        end
        cpu_req = 0; ext_req = 0;
        checks++; if (n !== 10) begin errors++; $display("FAIL starve_count got %0d exp 10", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_order[i] !== exp_order[i]) begin errors++; $display("FAIL starve_order[%0d] got %b exp %b (1=ext)", i, got_order[i], exp_order[i]); end
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_access();
        mem[8'h40] = 16'h1111;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h2222;
        step();                                                 // cycle 1 (first BUSY)
        checks++; if ({dbg_state, mem_we} !== {BUSY, 1'b0}) begin errors++; $display("FAIL rst_mid_c1 got %b exp 10", {dbg_state, mem_we}); end
        rst_n = 0; cpu_req = 0;
        step();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", dbg_state); end
        checks++; if ({cpu_ack, ext_ack, cpu_stall, mem_we, mem_re, cpu_rdata, ext_rdata, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL rst_mid_outs got %h exp 0", {cpu_ack, ext_ack, cpu_stall, mem_we, mem_re, cpu_rdata, ext_rdata, mem_addr, mem_wdata}); end
        rst_n = 1;
        repeat (3) begin
            step();
            checks++; if ({cpu_ack, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mid_noack got %b exp 00", {cpu_ack, mem_we}); end
        end
        checks++; if (mem[8'h40] !== 16'h1111) begin errors++; $display("FAIL rst_mid_mem got %h exp 1111", mem[8'h40]); end
    endtask

    task automatic test_acc1();
        c1_req = 1; c1_addr = 16'h0010;
        step();                                                 // cycle 1
        checks++; if ({d1_state, m1_re, m1_addr} !== {BUSY, 1'b1, 16'h0010}) begin errors++; $display("FAIL acc1_c1 got %h exp 3_0010", {d1_state, m1_re, m1_addr}); end
        step();                                                 // cycle 2
        checks++; if ({c1_ack, c1_rdata, m1_re} !== {1'b1, 16'h5545, 1'b0}) begin errors++; $display("FAIL acc1_c2 got %h exp 1_5545_0", {c1_ack, c1_rdata, m1_re}); end
        c1_req = 0;
        step();
        checks++; if ({c1_ack, d1_state} !== {1'b0, IDLE}) begin errors++; $display("FAIL acc1_c3 got %b exp 00", {c1_ack, d1_state}); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset();
        test_cpu_read();
        test_ext_write();
        test_back_to_back();
        test_starvation();
        test_reset_mid_access();
        test_acc1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
